// File: rtl/wallace_tree_mult16_if.sv
// Operand/product bundle for the 16x16 Wallace-tree multiplier.
interface wallace_tree_mult16_if;
  logic [15:0] input_a;
  logic [15:0] input_b;
  logic [31:0] result;

  modport master (output input_a, output input_b, input result);
  modport slave  (input input_a, input input_b, output result);
endinterface

// File: rtl/wallace_tree_mult16.sv
// 16x16 unsigned multiplier: Wallace carry-save reduction, final CPA, one output register.
module wallace_csa_stage #(
  parameter int N_IN  = 16,
  parameter int N_OUT = 2 * (N_IN / 3) + (N_IN % 3)
) (
  input  logic [N_IN-1:0][31:0]  rows_in,
  output logic [N_OUT-1:0][31:0] rows_out
);
  localparam int GROUPS = N_IN / 3;
  localparam int REST   = N_IN % 3;

  // Each triple of rows becomes a bitwise sum row plus a carry row shifted one column up.
  for (genvar g = 0; g < GROUPS; g++) begin : g_fa
    wallace_fa_row u_fa (
      .x   (rows_in[3*g]),
      .y   (rows_in[3*g+1]),
      .z   (rows_in[3*g+2]),
      .sum (rows_out[2*g]),
      .cry (rows_out[2*g+1])
    );
  end

  for (genvar r = 0; r < REST; r++) begin : g_pass
    assign rows_out[2*GROUPS+r] = rows_in[3*GROUPS+r];
  end
endmodule

module wallace_fa_row (
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic [31:0] z,
  output logic [31:0] sum,
  output logic [31:0] cry
);
  // Carry out of bit 31 is dropped: the true product never exceeds 32 bits.
  assign sum = x ^ y ^ z;
  assign cry = ((x & y) | (x & z) | (y & z)) << 1;
endmodule

module wallace_tree_mult16 (
  input  logic                  clk,
  input  logic                  rst_n,
  wallace_tree_mult16_if.slave  bus
);
  logic [15:0][31:0] pp;
  logic [10:0][31:0] st1;
  logic [7:0][31:0]  st2;
  logic [5:0][31:0]  st3;
  logic [3:0][31:0]  st4;
  logic [2:0][31:0]  st5;
  logic [1:0][31:0]  st6;
  logic [31:0]       product;

  for (genvar i = 0; i < 16; i++) begin : g_pp
    assign pp[i] = {16'h0, bus.input_a & {16{bus.input_b[i]}}} << i;
  end

  // Row counts per stage: 16 -> 11 -> 8 -> 6 -> 4 -> 3 -> 2.
  wallace_csa_stage #(.N_IN(16)) u_st1 (.rows_in(pp),  .rows_out(st1));
  wallace_csa_stage #(.N_IN(11)) u_st2 (.rows_in(st1), .rows_out(st2));
  wallace_csa_stage #(.N_IN(8))  u_st3 (.rows_in(st2), .rows_out(st3));
  wallace_csa_stage #(.N_IN(6))  u_st4 (.rows_in(st3), .rows_out(st4));
  wallace_csa_stage #(.N_IN(4))  u_st5 (.rows_in(st4), .rows_out(st5));
  wallace_csa_stage #(.N_IN(3))  u_st6 (.rows_in(st5), .rows_out(st6));

  assign product = st6[0] + st6[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.result <= 32'h0;
    else        bus.result <= product;
  end
endmodule

// File: tb/tb_wallace_tree_mult16.sv
// Directed bench for wallace_tree_mult16: reset, products, pipelining, async reset.
module tb_wallace_tree_mult16;
  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  wallace_tree_mult16_if mif ();

  wallace_tree_mult16 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (mif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Apply operands between edges, then sit just after the next rising edge.
  task automatic step(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    mif.input_a = a;
    mif.input_b = b;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] p;
    string       tag;
  } vec_t;

  vec_t vecs[10];

  initial begin
    n_chk  = 0;
    n_fail = 0;
    vecs[0] = '{16'd1408,  16'd1238,  32'd1743104,    "v_1408x1238"};
    vecs[1] = '{16'd10086, 16'd10086, 32'd101727396,  "v_square"};
    vecs[2] = '{16'hFFFF,  16'hFFFF,  32'hFFFE0001,   "v_max"};
    vecs[3] = '{16'h0000,  16'hFFFF,  32'h00000000,   "v_zero_a"};
    vecs[4] = '{16'hFFFF,  16'h0000,  32'h00000000,   "v_zero_b"};
    vecs[5] = '{16'd1,     16'd1,     32'd1,          "v_one"};
    vecs[6] = '{16'h8000,  16'h8000,  32'h40000000,   "v_msb_sq"};
    vecs[7] = '{16'hFFFF,  16'd1,     32'h0000FFFF,   "v_ident"};
    vecs[8] = '{16'd12345, 16'd6789,  32'd83810205,   "v_12345x6789"};
    vecs[9] = '{16'h8000,  16'd2,     32'h00010000,   "v_carry16"};

    rst_n = 1'b0;
    mif.input_a = 16'hFFFF;
    mif.input_b = 16'hFFFF;
    #2;
    chk("reset_early", mif.result, 32'h0);
    @(posedge clk); #1;
    chk("reset_after_edge", mif.result, 32'h0);
    @(posedge clk); #1;
    chk("reset_after_edge2", mif.result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      step(vecs[i].a, vecs[i].b);
      chk(vecs[i].tag, mif.result, vecs[i].p);
    end

    // Back-to-back: new operands each cycle; result must hold the previous product until the edge.
    step(16'd1408, 16'd1238);
    chk("b2b_0", mif.result, 32'd1743104);
    @(negedge clk);
    mif.input_a = 16'd10086; mif.input_b = 16'd10086;
    #1 chk("b2b_hold_0", mif.result, 32'd1743104);
    @(posedge clk); #1;
    chk("b2b_1", mif.result, 32'd101727396);
    step(16'd1408, 16'd1238);
    chk("b2b_2", mif.result, 32'd1743104);
    @(negedge clk);
    mif.input_a = 16'hFFFF; mif.input_b = 16'hFFFF;
    #1 chk("b2b_hold_2", mif.result, 32'd1743104);
    @(posedge clk); #1;
    chk("b2b_3", mif.result, 32'hFFFE0001);

    // Async reset between edges while the result is nonzero.
    step(16'd12345, 16'd6789);
    chk("pre_async", mif.result, 32'd83810205);
    #2 rst_n = 1'b0;
    #1 chk("async_clear", mif.result, 32'h0);
    @(negedge clk);
    chk("async_hold", mif.result, 32'h0);
    mif.input_a = 16'd10086; mif.input_b = 16'd10086;
    rst_n = 1'b1;
    #1 chk("async_release_noedge", mif.result, 32'h0);
    @(posedge clk); #1;
    chk("async_resume", mif.result, 32'd101727396);

    // Short pseudo-random sweep against the plain 32-bit product.
    for (int k = 0; k < 2000; k++) begin
      logic [15:0] ra;
      logic [15:0] rb;
      logic [31:0] rp;
      ra = 16'($urandom);
      rb = 16'($urandom);
      rp = {16'h0, ra} * {16'h0, rb};
      step(ra, rb);
      chk("rand", mif.result, rp);
    end

    if (n_fail == 0) $display("All tests passed.");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
